// File: rtl/wb_stage.sv
// wb_stage: dual-issue write-back stage with register file, bypassed read ports and commit counters
//   CLK, RESET                     clock, asynchronous active-high reset
//   MemtoRegN_PR, do_writebackN_PR, writeRegisterN_PR, aluResultN_PR, data_readN_PR
//                                  MEM/WB pipeline-register contents for slot N (1, 2)
//   writeDataN_WB, writeRegisterN_WB, do_writebackN_WB
//                                  per-slot write-back value/destination/enable forwarded to MEM
//   readRegister{A,B}{1,2}, readData{A,B}{1,2}
//                                  four decode read ports, bypassed from this cycle's commits
//   wb_count, conflict_count       committed-write and same-register dual-write counters
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NREGS = 2**AW,
  parameter int CW = 32
)(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          MemtoReg1_PR,
  input  logic          MemtoReg2_PR,
  input  logic          do_writeback1_PR,
  input  logic          do_writeback2_PR,
  input  logic [AW-1:0] writeRegister1_PR,
  input  logic [AW-1:0] writeRegister2_PR,
  input  logic [DW-1:0] aluResult1_PR,
  input  logic [DW-1:0] aluResult2_PR,
  input  logic [DW-1:0] data_read1_PR,
  input  logic [DW-1:0] data_read2_PR,
  output logic [DW-1:0] writeData1_WB,
  output logic [DW-1:0] writeData2_WB,
  output logic [AW-1:0] writeRegister1_WB,
  output logic [AW-1:0] writeRegister2_WB,
  output logic          do_writeback1_WB,
  output logic          do_writeback2_WB,
  input  logic [AW-1:0] readRegisterA1,
  input  logic [AW-1:0] readRegisterB1,
  input  logic [AW-1:0] readRegisterA2,
  input  logic [AW-1:0] readRegisterB2,
  output logic [DW-1:0] readDataA1,
  output logic [DW-1:0] readDataB1,
  output logic [DW-1:0] readDataA2,
  output logic [DW-1:0] readDataB2,
  output logic [CW-1:0] wb_count,
  output logic [CW-1:0] conflict_count
);
  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] wd1, wd2;
  logic eff1, eff2, collide;
  logic [CW-1:0] wb_cnt_q, wb_cnt_d, cf_cnt_q, cf_cnt_d;
  // Slot 2 is checked before slot 1 so the younger write wins on a collision.
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    return (a == '0) ? '0 :
           (eff2 && a == writeRegister2_PR) ? wd2 :
           (eff1 && a == writeRegister1_PR) ? wd1 : rf_q[a];
  endfunction
  always_comb begin
    wd1 = MemtoReg1_PR ? data_read1_PR : aluResult1_PR;
    wd2 = MemtoReg2_PR ? data_read2_PR : aluResult2_PR;
    eff1 = do_writeback1_PR && writeRegister1_PR != '0;
    eff2 = do_writeback2_PR && writeRegister2_PR != '0;
    collide = eff1 && eff2 && writeRegister1_PR == writeRegister2_PR;
    wb_cnt_d = wb_cnt_q + CW'(eff1) + CW'(eff2);
    cf_cnt_d = cf_cnt_q + CW'(collide);
  end
  // Combinational outputs are squashed while RESET is high.
  always_comb begin
    writeData1_WB = RESET ? '0 : wd1;
    writeData2_WB = RESET ? '0 : wd2;
    writeRegister1_WB = RESET ? '0 : writeRegister1_PR;
    writeRegister2_WB = RESET ? '0 : writeRegister2_PR;
    do_writeback1_WB = !RESET && eff1;
    do_writeback2_WB = !RESET && eff2;
    readDataA1 = RESET ? '0 : rd_port(readRegisterA1);
    readDataB1 = RESET ? '0 : rd_port(readRegisterB1);
    readDataA2 = RESET ? '0 : rd_port(readRegisterA2);
    readDataB2 = RESET ? '0 : rd_port(readRegisterB2);
    wb_count = wb_cnt_q;
    conflict_count = cf_cnt_q;
  end
  // Slot 2 is written last so it overrides slot 1 on the same address.
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (eff1) rf_q[writeRegister1_PR] <= wd1;
      if (eff2) rf_q[writeRegister2_PR] <= wd2;
    end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      wb_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      wb_cnt_q <= wb_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
endmodule
